// File: rtl/spi_master_driver_if.sv
// Host-side request/response bundle for spi_master_driver.
// The driver uses the slave modport; the requesting logic uses master.
interface spi_master_driver_if;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;

  modport master (output start, rw, addr, wdata, input busy, done, rdata);
  modport slave  (input start, rw, addr, wdata, output busy, done, rdata);
endinterface

// File: rtl/spi_master_driver.sv
// Single-byte SPI mode-0 master: 7-bit address, R/W bit, 8 data bits, MSB first.
// All pin outputs come straight from flops so the slave never sees glitches.
module spi_master_driver #(
  parameter int unsigned CLKDIV   = 8,
  parameter int unsigned CS_SETUP = 4,
  parameter int unsigned CS_HOLD  = 4,
  parameter int unsigned CS_IDLE  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_master_driver_if.slave  host,
  output logic                sclk_pin,
  output logic                cs_pin,
  output logic                mosi_pin,
  input  logic                miso_pin
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  localparam int CW = 16;
  localparam logic [CW-1:0] C_DIV_LAST   = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] C_SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] C_HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] C_IDLE_LAST  = CW'(CS_IDLE - 1);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;
  logic [3:0]    r_bit,   w_bit_nxt;
  logic [15:0]   r_sh,    w_sh_nxt;
  logic [7:0]    r_cap,   w_cap_nxt;
  logic [7:0]    r_rdata, w_rdata_nxt;
  logic          r_rw,    w_rw_nxt;
  logic          r_sclk,  w_sclk_nxt;
  logic          r_cs,    w_cs_nxt;
  logic          r_mosi,  w_mosi_nxt;
  logic          r_busy,  w_busy_nxt;
  logic          r_done,  w_done_nxt;
  logic [1:0]    r_miso_sync;
  logic [15:0]   w_word;

  assign w_word = {host.addr, host.rw, host.rw ? 8'h00 : host.wdata};

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_sh        <= '0;
      r_cap       <= '0;
      r_rdata     <= '0;
      r_rw        <= 1'b0;
      r_sclk      <= 1'b0;
      r_cs        <= 1'b1;
      r_mosi      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_miso_sync <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit       <= w_bit_nxt;
      r_sh        <= w_sh_nxt;
      r_cap       <= w_cap_nxt;
      r_rdata     <= w_rdata_nxt;
      r_rw        <= w_rw_nxt;
      r_sclk      <= w_sclk_nxt;
      r_cs        <= w_cs_nxt;
      r_mosi      <= w_mosi_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_miso_sync <= {r_miso_sync[0], miso_pin};
    end
  end

  // NOTE: every next-state signal is given its hold value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_sh_nxt    = r_sh;
    w_cap_nxt   = r_cap;
    w_rdata_nxt = r_rdata;
    w_rw_nxt    = r_rw;
    w_sclk_nxt  = r_sclk;
    w_cs_nxt    = r_cs;
    w_mosi_nxt  = r_mosi;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_cs_nxt   = 1'b1;
        w_sclk_nxt = 1'b0;
        w_busy_nxt = 1'b0;
        if (host.start) begin
          w_rw_nxt    = host.rw;
          w_sh_nxt    = w_word;
          w_mosi_nxt  = w_word[15];
          w_cs_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_cnt == C_SETUP_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_SHIFT;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_SHIFT: begin
        if (r_cnt != C_DIV_LAST) begin
          w_cnt_nxt = r_cnt + 16'd1;
        end else begin
          w_cnt_nxt = '0;
          if (!r_sclk) begin
            w_sclk_nxt = 1'b1;
          end else begin
            // Closing a high half: capture MISO in the data phase, then fall.
            w_sclk_nxt = 1'b0;
            if (r_bit[3]) w_cap_nxt = {r_cap[6:0], r_miso_sync[1]};
            if (r_bit == 4'd15) begin
              w_mosi_nxt  = 1'b0;
              w_state_nxt = S_HOLD;
            end else begin
              w_mosi_nxt = r_sh[14];
              w_sh_nxt   = {r_sh[14:0], 1'b0};
              w_bit_nxt  = r_bit + 4'd1;
            end
          end
        end
      end
      S_HOLD: begin
        if (r_cnt == C_HOLD_LAST) begin
          w_cnt_nxt   = '0;
          w_cs_nxt    = 1'b1;
          w_state_nxt = S_GAP;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_GAP: begin
        if (r_cnt == C_IDLE_LAST) begin
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          if (r_rw) w_rdata_nxt = r_cap;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign sclk_pin   = r_sclk;
  assign cs_pin     = r_cs;
  assign mosi_pin   = r_mosi;
  assign host.busy  = r_busy;
  assign host.done  = r_done;
  assign host.rdata = r_rdata;

endmodule

// File: tb/tb_spi_master_driver.sv
// Directed bench: one default-timing driver with a mode-0 slave model, and a
// fast-timing driver with start held high for back-to-back frames.
module tb_spi_master_driver;
  logic clk = 1'b0;
  logic rst_n;
  logic sclk, cs, mosi, miso;
  logic sclk2, cs2, mosi2;
  logic miso2 = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  spi_master_driver_if u_if ();
  spi_master_driver_if u_if2 ();

  spi_master_driver u_dut (
    .clk(clk), .rst_n(rst_n), .host(u_if),
    .sclk_pin(sclk), .cs_pin(cs), .mosi_pin(mosi), .miso_pin(miso)
  );

  spi_master_driver #(.CLKDIV(2), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .host(u_if2),
    .sclk_pin(sclk2), .cs_pin(cs2), .mosi_pin(mosi2), .miso_pin(miso2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one frame on u_dut and watches the pins for up to 290 cycles after
  // accept. Cycle 0 is the negedge right after the accepting posedge.
  task automatic run_frame(input logic f_rw, input logic [6:0] f_addr,
                           input logic [7:0] f_wdata, input logic [7:0] slave_data,
                           input bit poke, input int abort_at,
                           output int rises, output logic [15:0] mosi_word,
                           output bit cs_bad, output int dones, output int done_cyc);
    logic prev_sclk = 1'b0;
    int   falls = 0;
    bit   poked = 1'b0;
    rises = 0; mosi_word = '0; cs_bad = 1'b0; dones = 0; done_cyc = -1;
    miso = 1'b0;
    @(negedge clk);
    u_if.rw = f_rw; u_if.addr = f_addr; u_if.wdata = f_wdata; u_if.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    u_if.start = 1'b0;
    for (int cyc = 1; cyc <= 290; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (poked) u_if.start = 1'b0;
      if (u_if.done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (sclk && !prev_sclk) begin
        rises++;
        mosi_word = {mosi_word[14:0], mosi};
        if (cs) cs_bad = 1'b1;
        if (poke && rises == 6) begin
          u_if.start = 1'b1; u_if.rw = 1'b1; u_if.addr = 7'h7F; u_if.wdata = 8'h00;
          poked = 1'b1;
        end
        if (rises == abort_at) begin
          rst_n = 1'b0;
          break;
        end
      end
      if (!sclk && prev_sclk) begin
        falls++;
        if (falls >= 8 && falls <= 15) miso = slave_data[15 - falls];
      end
      prev_sclk = sclk;
    end
  endtask

  initial begin
    int          rises, dones, done_cyc;
    logic [15:0] mw;
    bit          cs_bad;
    bit          bad;
    int          d1, d2, run, min_gap, r2;
    bit          seen_low;
    logic        p2;

    // Reset held for three cycles with start asserted.
    rst_n = 1'b0; miso = 1'b0;
    u_if.start = 1'b1; u_if.rw = 1'b0; u_if.addr = 7'h00; u_if.wdata = 8'h00;
    u_if2.start = 1'b0; u_if2.rw = 1'b0; u_if2.addr = 7'h2A; u_if2.wdata = 8'hA5;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (sclk !== 1'b0 || cs !== 1'b1) bad = 1'b1;
    end
    check("rst_no_sclk_activity", bad, 1'b0);
    check("rst_cs", cs, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_busy", u_if.busy, 1'b0);
    check("rst_done", u_if.done, 1'b0);
    check("rst_rdata", u_if.rdata, 8'h00);
    u_if.start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write 8'hA5 to 7'h2A.
    run_frame(1'b0, 7'h2A, 8'hA5, 8'h00, 1'b0, 0, rises, mw, cs_bad, dones, done_cyc);
    check("wr_rises", rises, 16);
    check("wr_byte0", mw[15:8], 8'h54);
    check("wr_byte1", mw[7:0], 8'hA5);
    check("wr_cs_low", cs_bad, 1'b0);
    check("wr_latency", done_cyc, 268);
    check("wr_done_count", dones, 1);
    check("wr_rdata_kept", u_if.rdata, 8'h00);
    check("wr_idle_cs", cs, 1'b1);

    // Read 7'h05 with the slave returning 8'h3C.
    run_frame(1'b1, 7'h05, 8'hFF, 8'h3C, 1'b0, 0, rises, mw, cs_bad, dones, done_cyc);
    check("rd_rises", rises, 16);
    check("rd_byte0", mw[15:8], 8'h0B);
    check("rd_data_mosi", mw[7:0], 8'h00);
    check("rd_latency", done_cyc, 268);
    check("rd_rdata", u_if.rdata, 8'h3C);

    // start pulsed mid-SHIFT with a different address is ignored.
    run_frame(1'b0, 7'h33, 8'h96, 8'h00, 1'b1, 0, rises, mw, cs_bad, dones, done_cyc);
    u_if.rw = 1'b0;
    check("ign_rises", rises, 16);
    check("ign_word", mw, 16'h6696);
    check("ign_done_count", dones, 1);
    check("ign_latency", done_cyc, 268);
    check("ign_rdata_kept", u_if.rdata, 8'h3C);
    check("ign_no_restart", u_if.busy, 1'b0);

    // Reset after the 5th rising edge abandons the frame.
    run_frame(1'b0, 7'h10, 8'h01, 8'h00, 1'b0, 5, rises, mw, cs_bad, dones, done_cyc);
    check("abort_rises", rises, 5);
    @(posedge clk);
    @(negedge clk);
    check("abort_cs", cs, 1'b1);
    check("abort_sclk", sclk, 1'b0);
    check("abort_busy", u_if.busy, 1'b0);
    bad = (u_if.done !== 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (u_if.done !== 1'b0 || u_if.busy !== 1'b0) bad = 1'b1;
    end
    check("abort_no_done", bad, 1'b0);
    check("abort_rdata_cleared", u_if.rdata, 8'h00);

    run_frame(1'b0, 7'h7F, 8'hFF, 8'h00, 1'b0, 0, rises, mw, cs_bad, dones, done_cyc);
    check("post_rises", rises, 16);
    check("post_word", mw, 16'hFEFF);
    check("post_latency", done_cyc, 268);

    // Fast timing, start held high: back-to-back frames.
    @(negedge clk);
    u_if2.start = 1'b1;
    d1 = -1; d2 = -1; run = 0; min_gap = 1000; r2 = 0; seen_low = 1'b0; p2 = 1'b0;
    for (int c = 1; c <= 250; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (u_if2.done) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      if (sclk2 && !p2 && d1 >= 0 && d2 < 0) r2++;
      p2 = sclk2;
      if (cs2) run++;
      else begin
        if (seen_low && run > 0 && run < min_gap) min_gap = run;
        run = 0;
        seen_low = 1'b1;
      end
    end
    u_if2.start = 1'b0;
    check("fast_first_done", d1, 68);
    check("fast_low_between_dones", d2 - d1 - 1, 67);
    check("fast_rises_per_frame", r2, 16);
    check("fast_cs_gap_ge1", (min_gap >= 1 && min_gap < 1000), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
